// File: rtl/pixel_config_pkg.sv
// pixel_config_pkg: state encoding and shift-direction constants for the pixel config shift engine
package pixel_config_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, SHIFT_LO, SHIFT_HI, LOAD, FIN} state_t;
  localparam bit SHIFT_MSB_FIRST = 1'b1;
  localparam bit SHIFT_LSB_FIRST = 1'b0;
endpackage

// File: rtl/pixel_config_bit_timer.sv
// pixel_config_bit_timer: counts CLK_DIV cycles per S_CLK half-period, restarting whenever the FSM changes state
//   clk, rst : clock and synchronous active-high reset
//   clr      : restart the count (state change)
//   first    : first cycle of the current half-period
//   tick     : last cycle of the current half-period
module pixel_config_bit_timer #(
  parameter int CLK_DIV   = 2,
  parameter int DIV_WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic first,
  output logic tick
);
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  assign tick  = cnt_q == DIV_WIDTH'(CLK_DIV - 1);
  assign first = cnt_q == '0;
  always_comb cnt_d = (clr || tick) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/pixel_config_shift_engine.sv
// pixel_config_shift_engine: pops config words from a FWFT FIFO, shifts them onto the pixel chain and captures readback
//   CLK_IN, RESET          : clock, synchronous active-high reset
//   START                  : rising edge launches one frame
//   DATA_IN, EMPTY, RD_FIFO: FIFO head word, empty flag, pop strobe
//   S_CLK, S_DATA, S_LOAD  : chain clock, data, latch pulse; S_DOUT chain readback
//   RB_DATA, RB_VALID      : last readback word and its update strobe
//   BUSY, DONE            : not idle, end-of-frame strobe; ERR_UNDERFLOW sticky mid-frame FIFO underflow
module pixel_config_shift_engine
  import pixel_config_pkg::*;
#(
  parameter int DATA_WIDTH      = 15,
  parameter bit SHIFT_DIRECTION = SHIFT_MSB_FIRST,
  parameter int CNT_WIDTH       = 4,
  parameter int WORDS_PER_FRAME = 8,
  parameter int WCNT_WIDTH      = 8,
  parameter int CLK_DIV         = 2,
  parameter int DIV_WIDTH       = 8
) (
  input  logic                  CLK_IN,
  input  logic                  RESET,
  input  logic                  START,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  input  logic                  EMPTY,
  output logic                  RD_FIFO,
  output logic                  S_CLK,
  output logic                  S_DATA,
  output logic                  S_LOAD,
  input  logic                  S_DOUT,
  output logic [DATA_WIDTH-1:0] RB_DATA,
  output logic                  RB_VALID,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR_UNDERFLOW
);
  localparam bit MSB = SHIFT_DIRECTION == SHIFT_MSB_FIRST;
  state_t st_q, st_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d, rb_q, rb_d, rbd_q, rbd_d;
  logic [CNT_WIDTH-1:0] bit_q, bit_d;
  logic [WCNT_WIDTH-1:0] wrd_q, wrd_d;
  logic start_q, err_q, err_d, rbv_q, rbv_d, first, tick;
  pixel_config_bit_timer #(.CLK_DIV(CLK_DIV), .DIV_WIDTH(DIV_WIDTH)) u_timer (
    .clk(CLK_IN), .rst(RESET), .clr(st_d != st_q), .first(first), .tick(tick)
  );
  always_comb begin
    st_d  = st_q;
    sh_d  = sh_q;
    bit_d = bit_q;
    wrd_d = wrd_q;
    err_d = err_q;
    rbd_d = rbd_q;
    rbv_d = 1'b0;
    // readback is taken on the first cycle of S_CLK high; rb_d also feeds RB_DATA so CLK_DIV=1 keeps the last bit
    rb_d  = (st_q == SHIFT_HI && first) ?
            (MSB ? {rb_q[DATA_WIDTH-2:0], S_DOUT} : {S_DOUT, rb_q[DATA_WIDTH-1:1]}) : rb_q;
    case (st_q)
      IDLE: if (START && !start_q) begin
        st_d  = FETCH;
        wrd_d = '0;
        err_d = 1'b0;
      end
      FETCH: if (EMPTY) err_d = err_q | (wrd_q != '0);
      else begin
        sh_d  = DATA_IN;
        bit_d = '0;
        st_d  = SHIFT_LO;
      end
      SHIFT_LO: st_d = tick ? SHIFT_HI : SHIFT_LO;
      SHIFT_HI: if (tick) begin
        if (bit_q != CNT_WIDTH'(DATA_WIDTH - 1)) begin
          bit_d = bit_q + 1'b1;
          sh_d  = MSB ? sh_q << 1 : sh_q >> 1;
          st_d  = SHIFT_LO;
        end else begin
          rbd_d = rb_d;
          rbv_d = 1'b1;
          wrd_d = (wrd_q != WCNT_WIDTH'(WORDS_PER_FRAME - 1)) ? wrd_q + 1'b1 : wrd_q;
          st_d  = (wrd_q != WCNT_WIDTH'(WORDS_PER_FRAME - 1)) ? FETCH : LOAD;
        end
      end
      LOAD: st_d = tick ? FIN : LOAD;
      default: st_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK_IN) begin
    if (RESET) begin
      st_q    <= IDLE;
      sh_q    <= '0;
      rb_q    <= '0;
      rbd_q   <= '0;
      bit_q   <= '0;
      wrd_q   <= '0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
      rbv_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      sh_q    <= sh_d;
      rb_q    <= rb_d;
      rbd_q   <= rbd_d;
      bit_q   <= bit_d;
      wrd_q   <= wrd_d;
      start_q <= START;
      err_q   <= err_d;
      rbv_q   <= rbv_d;
    end
  end
  assign RD_FIFO       = st_q == FETCH && !EMPTY;
  assign S_CLK         = st_q == SHIFT_HI;
  assign S_DATA        = (st_q == SHIFT_LO || st_q == SHIFT_HI) && (MSB ? sh_q[DATA_WIDTH-1] : sh_q[0]);
  assign S_LOAD        = st_q == LOAD;
  assign RB_DATA       = rbd_q;
  assign RB_VALID      = rbv_q;
  assign BUSY          = st_q != IDLE;
  assign DONE          = st_q == FIN;
  assign ERR_UNDERFLOW = err_q;
endmodule
